// File: rtl/u712_pkg.sv
// Shared types and helpers for the U712 cycle-termination path.
// FSM state encoding, align-kind constants and counter sizing.
package u712_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ALIGN,
        ACK,
        ERR,
        RECOVER
    } state_t;

    localparam logic KIND_ACK = 1'b0;
    localparam logic KIND_ERR = 1'b1;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/u712_prio_enc.sv
// Lowest-index-wins one-hot priority encoder with a multiple-request flag.
// Purely combinational, zero latency, no backpressure.
module u712_prio_enc #(
    parameter int N_SRC = 2
) (
    input  logic [N_SRC-1:0] i_req,
    output logic [N_SRC-1:0] o_onehot,
    output logic             o_any,
    output logic             o_multi
);
    logic w_seen;

    always_comb begin
        o_onehot = '0;
        o_multi  = 1'b0;
        w_seen   = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (i_req[i]) begin
                if (w_seen) begin
                    o_multi = 1'b1;
                end else begin
                    o_onehot[i] = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
        o_any = w_seen;
    end

endmodule

// File: rtl/u712_cycle_term_n.sv
// Arbitrates N_SRC termination requests into a CLK40-aligned 68040 TACKn; registered outputs.
// Optional bus-timeout watchdog driving TEAn is built only when BUS_TIMEOUT_EN is defined.
module u712_cycle_term_n
    import u712_pkg::*;
#(
    parameter int N_SRC       = 2,
    parameter int TACK_CYCLES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic             CLK80,
    input  logic             RESETn,
    input  logic             TSn,
    input  logic             CLK40_PH,
    input  logic [N_SRC-1:0] TERM_REQ,
    output logic             TACKn,
    output logic             TEAn,
    output logic             BUSY,
    output logic [N_SRC-1:0] TERM_SRC,
    output logic             TIMEOUT_STB,
    output logic             COLLIDE
);
    localparam int HW = cnt_width(TACK_CYCLES);

    state_t           r_state, w_state_nxt;
    logic [HW-1:0]    r_hold, w_hold_nxt;
    logic             r_tackn, w_tackn_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_collide, w_collide_nxt;
    logic [N_SRC-1:0] r_term_src, w_term_src_nxt;
    logic [N_SRC-1:0] w_onehot;
    logic             w_any;
    logic             w_multi;
`ifdef BUS_TIMEOUT_EN
    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_kind, w_kind_nxt;
    logic             r_tean, w_tean_nxt;
    logic             r_tmo_stb, w_tmo_stb_nxt;
    logic             w_tmo;

    assign w_cnt_inc = (r_cnt == CW'(TIMEOUT - 1)) ? r_cnt : r_cnt + 1'b1;
    // Fires on the edge that advances the count to TIMEOUT-1.
    assign w_tmo     = (r_cnt == CW'(TIMEOUT - 2));
`endif

    u712_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .i_req    (TERM_REQ),
        .o_onehot (w_onehot),
        .o_any    (w_any),
        .o_multi  (w_multi)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold;
        w_tackn_nxt    = 1'b1;
        w_busy_nxt     = r_busy;
        w_collide_nxt  = 1'b0;
        w_term_src_nxt = r_term_src;
`ifdef BUS_TIMEOUT_EN
        w_cnt_nxt      = r_cnt;
        w_kind_nxt     = r_kind;
        w_tean_nxt     = 1'b1;
        w_tmo_stb_nxt  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!TSn) begin
                    w_state_nxt    = WAIT;
                    w_busy_nxt     = 1'b1;
                    w_term_src_nxt = '0;
`ifdef BUS_TIMEOUT_EN
                    w_cnt_nxt      = '0;
`endif
                end
            end
            WAIT: begin
`ifdef BUS_TIMEOUT_EN
                w_cnt_nxt = w_cnt_inc;
`endif
                if (w_any) begin
                    w_term_src_nxt = w_onehot;
                    w_collide_nxt  = w_multi;
                    w_hold_nxt     = '0;
                    if (CLK40_PH) begin
                        w_state_nxt = ACK;
                        w_tackn_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ALIGN;
`ifdef BUS_TIMEOUT_EN
                        w_kind_nxt  = KIND_ACK;
`endif
                    end
                end
`ifdef BUS_TIMEOUT_EN
                else if (w_tmo) begin
                    w_tmo_stb_nxt = 1'b1;
                    w_hold_nxt    = '0;
                    if (CLK40_PH) begin
                        w_state_nxt = ERR;
                        w_tean_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ALIGN;
                        w_kind_nxt  = KIND_ERR;
                    end
                end
`endif
            end
            ALIGN: begin
                if (CLK40_PH) begin
                    w_hold_nxt = '0;
`ifdef BUS_TIMEOUT_EN
                    if (r_kind == KIND_ERR) begin
                        w_state_nxt = ERR;
                        w_tean_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ACK;
                        w_tackn_nxt = 1'b0;
                    end
`else
                    w_state_nxt = ACK;
                    w_tackn_nxt = 1'b0;
`endif
                end
            end
            ACK: begin
                if (r_hold == HW'(TACK_CYCLES - 1)) begin
                    w_state_nxt = RECOVER;
                end else begin
                    w_hold_nxt  = r_hold + 1'b1;
                    w_tackn_nxt = 1'b0;
                end
            end
`ifdef BUS_TIMEOUT_EN
            ERR: begin
                if (r_hold == HW'(TACK_CYCLES - 1)) begin
                    w_state_nxt = RECOVER;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                    w_tean_nxt = 1'b0;
                end
            end
`endif
            RECOVER: begin
                // A new TSn here starts a back-to-back cycle without dropping BUSY.
                if (!TSn) begin
                    w_state_nxt    = WAIT;
                    w_term_src_nxt = '0;
`ifdef BUS_TIMEOUT_EN
                    w_cnt_nxt      = '0;
`endif
                end else begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK80 or negedge RESETn) begin
        if (!RESETn) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_tackn    <= 1'b1;
            r_busy     <= 1'b0;
            r_collide  <= 1'b0;
            r_term_src <= '0;
`ifdef BUS_TIMEOUT_EN
            r_cnt      <= '0;
            r_kind     <= KIND_ACK;
            r_tean     <= 1'b1;
            r_tmo_stb  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_tackn    <= w_tackn_nxt;
            r_busy     <= w_busy_nxt;
            r_collide  <= w_collide_nxt;
            r_term_src <= w_term_src_nxt;
`ifdef BUS_TIMEOUT_EN
            r_cnt      <= w_cnt_nxt;
            r_kind     <= w_kind_nxt;
            r_tean     <= w_tean_nxt;
            r_tmo_stb  <= w_tmo_stb_nxt;
`endif
        end
    end

    assign TACKn    = r_tackn;
    assign BUSY     = r_busy;
    assign COLLIDE  = r_collide;
    assign TERM_SRC = r_term_src;
`ifdef BUS_TIMEOUT_EN
    assign TEAn        = r_tean;
    assign TIMEOUT_STB = r_tmo_stb;
`else
    assign TEAn        = 1'b1;
    assign TIMEOUT_STB = 1'b0;
`endif

endmodule

// File: tb/tb_u712_cycle_term_n.sv
// Bench for u712_cycle_term_n: directed scenarios plus randomized bus cycles
// checked against a transaction-level model of the termination rules.
module tb_u712_cycle_term_n;
    localparam int N  = 2;
    localparam int TC = 2;
    localparam int TO = 16;

    logic         CLK80 = 1'b0;
    logic         RESETn;
    logic         TSn;
    logic         CLK40_PH;
    logic [N-1:0] TERM_REQ;
    logic         TACKn;
    logic         TEAn;
    logic         BUSY;
    logic [N-1:0] TERM_SRC;
    logic         TIMEOUT_STB;
    logic         COLLIDE;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    u712_cycle_term_n #(.N_SRC(N), .TACK_CYCLES(TC), .TIMEOUT(TO)) dut (
        .CLK80       (CLK80),
        .RESETn      (RESETn),
        .TSn         (TSn),
        .CLK40_PH    (CLK40_PH),
        .TERM_REQ    (TERM_REQ),
        .TACKn       (TACKn),
        .TEAn        (TEAn),
        .BUSY        (BUSY),
        .TERM_SRC    (TERM_SRC),
        .TIMEOUT_STB (TIMEOUT_STB),
        .COLLIDE     (COLLIDE)
    );

    always #5 CLK80 = ~CLK80;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CLK80 edge; CLK40_PH alternates as the real CLK40 phase does.
    task automatic step();
        @(posedge CLK80);
        #1;
        CLK40_PH = ~CLK40_PH;
    endtask

    function automatic logic [N-1:0] ref_win(input logic [N-1:0] r);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                v[i] = 1'b1;
                return v;
            end
        end
        return v;
    endfunction

    function automatic int popc(input logic [N-1:0] r);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(r[i]);
        return c;
    endfunction

    task automatic start_cycle();
        TERM_REQ = N'($urandom);
        TSn = 1'b0;
        step();
        TSn = 1'b1;
        TERM_REQ = '0;
        chk("start_busy", BUSY, 1);
        chk("start_src_clr", TERM_SRC, 0);
        chk("start_tackn", TACKn, 1);
    endtask

    task automatic wait_edges(input int n);
        TERM_REQ = '0;
        for (int k = 0; k < n; k++) begin
            step();
            chk("wait_tackn", TACKn, 1);
            chk("wait_tean", TEAn, 1);
            chk("wait_stb", TIMEOUT_STB, 0);
        end
    endtask

    // From the request edge to the end of the cycle; optionally chains a new TSn in RECOVER.
    task automatic run_term(input logic [N-1:0] req, input bit b2b);
        logic         p;
        logic [N-1:0] exp_src;
        exp_src  = ref_win(req);
        p        = CLK40_PH;
        TERM_REQ = req;
        step();
        TERM_REQ = N'($urandom);
        chk("collide", COLLIDE, logic'(popc(req) > 1));
        chk("term_src", TERM_SRC, exp_src);
        chk("stb_on_req", TIMEOUT_STB, 0);
        if (!p) begin
            chk("align_tackn", TACKn, 1);
            step();
            chk("collide_once", COLLIDE, 0);
        end
        for (int k = 0; k < TC; k++) begin
            chk("ack_tackn", TACKn, 0);
            chk("ack_tean", TEAn, 1);
            chk("ack_src_held", TERM_SRC, exp_src);
            step();
        end
        chk("rec_tackn", TACKn, 1);
        chk("rec_busy", BUSY, 1);
        TERM_REQ = '0;
        TSn = b2b ? 1'b0 : 1'b1;
        step();
        TSn = 1'b1;
        chk("end_busy", BUSY, logic'(b2b));
        chk("end_src", TERM_SRC, b2b ? '0 : exp_src);
    endtask

    initial begin
        bit           b2b;
        bit           in_wait;
        logic         p;
        int           bad;

        RESETn   = 1'b1;
        TSn      = 1'b1;
        CLK40_PH = 1'b0;
        TERM_REQ = '0;
        #2 RESETn = 1'b0;
        #10;
        chk("rst_tackn", TACKn, 1);
        chk("rst_tean", TEAn, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_src", TERM_SRC, 0);
        chk("rst_stb", TIMEOUT_STB, 0);
        chk("rst_collide", COLLIDE, 0);
        @(negedge CLK80);
        RESETn = 1'b1;
        wait_edges(2);
        chk("idle_busy", BUSY, 0);

        // Single request on a CLK40 edge three edges after TSn.
        start_cycle();
        wait_edges(2);
        if (!CLK40_PH) wait_edges(1);
        run_term(2'b01, 1'b0);

        // Colliding requests off-phase: one ALIGN edge.
        start_cycle();
        if (CLK40_PH) wait_edges(1);
        run_term(2'b11, 1'b0);

        // Randomized cycles, some back-to-back.
        in_wait = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (!in_wait) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                    TERM_REQ = N'($urandom);
                    step();
                    chk("gap_busy", BUSY, 0);
                    chk("gap_tackn", TACKn, 1);
                end
                start_cycle();
            end
            wait_edges(int'($urandom_range(0, 5)));
            b2b = 1'($urandom_range(0, 1));
            run_term(N'($urandom_range(1, 3)), b2b);
            in_wait = b2b;
        end
        if (in_wait) run_term(2'b10, 1'b0);

        // Asynchronous reset while TACKn is low.
        start_cycle();
        if (!CLK40_PH) wait_edges(1);
        TERM_REQ = 2'b01;
        step();
        TERM_REQ = '0;
        chk("pre_rst_tackn", TACKn, 0);
        #2 RESETn = 1'b0;
        #1;
        chk("mid_rst_tackn", TACKn, 1);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_src", TERM_SRC, 0);
        @(negedge CLK80);
        RESETn = 1'b1;
        start_cycle();
        run_term(2'b10, 1'b0);

`ifdef BUS_TIMEOUT_EN
        // Watchdog: no requests, fires on edge TO-1 after TSn.
        start_cycle();
        wait_edges(TO - 2);
        p = CLK40_PH;
        step();
        chk("tmo_stb", TIMEOUT_STB, 1);
        chk("tmo_tackn", TACKn, 1);
        if (!p) begin
            chk("tmo_align_tean", TEAn, 1);
            step();
            chk("tmo_stb_once", TIMEOUT_STB, 0);
        end
        for (int k = 0; k < TC; k++) begin
            chk("err_tean", TEAn, 0);
            chk("err_tackn", TACKn, 1);
            step();
        end
        chk("err_rec_tean", TEAn, 1);
        chk("err_src", TERM_SRC, 0);
        step();
        chk("err_end_busy", BUSY, 0);

        // Request on the timeout edge wins.
        start_cycle();
        wait_edges(TO - 2);
        run_term(2'b10, 1'b0);
`else
        // No watchdog: a cycle without requests never terminates.
        start_cycle();
        bad = 0;
        p   = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (TACKn !== 1'b1 || TEAn !== 1'b1 || BUSY !== 1'b1 || TIMEOUT_STB !== 1'b0) bad++;
        end
        chk("hang_1000_edges", 16'(bad), 0);
        #2 RESETn = 1'b0;
        @(negedge CLK80);
        RESETn = 1'b1;
        start_cycle();
        run_term(2'b01, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
